// File: rtl/cpu_pkg.sv
// Shared core-side definitions: default store widths and the store-buffer entry layout.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_storage.sv
// Store-buffer entry array: one write port, async head read, and (with
// STORE_BUF_COALESCE_EN) an async read of the newest entry.
module sb_storage #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 64,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [PTR_W-1:0]   widx,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   ridx,
  output logic [ENTRY_W-1:0] head
`ifdef STORE_BUF_COALESCE_EN
  ,
  input  logic [PTR_W-1:0]   nidx,
  output logic [ENTRY_W-1:0] newest
`endif
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx] = wdata;
  end

  // Cleared on reset so the bus sees zero address/data while idle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head = mem_q[ridx];

`ifdef STORE_BUF_COALESCE_EN
  assign newest = mem_q[nidx];
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: captures core stores into a FIFO and drains them to a
// valid/ready bus. Define STORE_BUF_COALESCE_EN to merge stores to the newest address.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_we,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     bus_valid,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_data,
  input  logic                     bus_ready
);

  import cpu_pkg::*;

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               push, pop, drop, coalesce, wr_en;
  logic [PTR_W-1:0]   wr_idx;
  logic [ENTRY_W-1:0] head;

`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0]   newest_idx;
  logic [ENTRY_W-1:0] newest;
  assign newest_idx = wr_ptr_q - PTR_W'(1);
`endif

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign bus_valid = !empty;
  assign bus_addr  = head[ENTRY_W-1:DATA_W];
  assign bus_data  = head[DATA_W-1:0];
  assign pop       = bus_valid && bus_ready;

  always_comb begin
    coalesce = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    // Never merge into an entry that is leaving on the bus this cycle.
    coalesce = mem_we && !empty && (mem_addr == newest[ENTRY_W-1:DATA_W])
               && !((count_q == CNT_W'(1)) && pop);
`endif
    push   = mem_we && !coalesce && (!full || pop);
    drop   = mem_we && !coalesce && full && !pop;
    wr_en  = push || coalesce;
    wr_idx = wr_ptr_q;
`ifdef STORE_BUF_COALESCE_EN
    if (coalesce) wr_idx = newest_idx;
`endif

    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q || drop;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  sb_storage #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .PTR_W   (PTR_W)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .widx  (wr_idx),
    .wdata ({mem_addr, mem_data}),
    .ridx  (rd_ptr_q),
    .head  (head)
`ifdef STORE_BUF_COALESCE_EN
    ,
    .nidx   (newest_idx),
    .newest (newest)
`endif
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer (DEPTH=4, 32-bit address/data).
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        bus_ready = 1'b0;
  logic        full, empty, overflow, bus_valid;
  logic [2:0]  count;
  logic [31:0] bus_addr, bus_data;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        rdy;
    logic        v;
    logic [31:0] ea;
    logic [31:0] ed;
    int          cnt;
    logic        ovf;
  } vec_t;

  vec_t tv[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_state(input string tag, input logic v, input logic [31:0] ea,
                             input logic [31:0] ed, input int cnt, input logic ovf);
    chk({tag, ".valid"},    32'(bus_valid), 32'(v));
    chk({tag, ".count"},    32'(count),     32'(cnt));
    chk({tag, ".empty"},    32'(empty),     32'(cnt == 0));
    chk({tag, ".full"},     32'(full),      32'(cnt == 4));
    chk({tag, ".overflow"}, 32'(overflow),  32'(ovf));
    if (v) begin
      chk({tag, ".addr"}, bus_addr, ea);
      chk({tag, ".data"}, bus_data, ed);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    mem_we = we; mem_addr = a; mem_data = d; bus_ready = rdy;
  endtask

  task automatic add(input string n, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic rdy, input logic v, input logic [31:0] ea, input logic [31:0] ed,
                     input int cnt, input logic ovf);
    vec_t t;
    t.name = n; t.we = we; t.a = a; t.d = d; t.rdy = rdy;
    t.v = v; t.ea = ea; t.ed = ed; t.cnt = cnt; t.ovf = ovf;
    tv.push_back(t);
  endtask

  task automatic step_check(input string tag, input logic v, input logic [31:0] ea,
                            input logic [31:0] ed, input int cnt, input logic ovf);
    @(posedge clk); #1;
    check_state(tag, v, ea, ed, cnt, ovf);
  endtask

  initial begin
    //      name        we  addr   data     rdy v  exp_addr exp_data cnt ovf
    add("single",       1, 32'h10, 32'hDEAD, 1, 1, 32'h10, 32'hDEAD, 1, 0);
    add("single_pop",   0, 0,      0,        1, 0, 0,      0,        0, 0);
    add("fill0",        1, 0,      32'hA0,   0, 1, 0,      32'hA0,   1, 0);
    add("fill1",        1, 1,      32'hA1,   0, 1, 0,      32'hA0,   2, 0);
    add("fill2",        1, 2,      32'hA2,   0, 1, 0,      32'hA0,   3, 0);
    add("fill3",        1, 3,      32'hA3,   0, 1, 0,      32'hA0,   4, 0);
    add("ovf_drop",     1, 32'h20, 32'hFF,   0, 1, 0,      32'hA0,   4, 1);
    add("ovf_sticky",   0, 0,      0,        0, 1, 0,      32'hA0,   4, 1);
    add("full_pushpop", 1, 32'h30, 32'hB0,   1, 1, 1,      32'hA1,   4, 1);
    add("drain1",       0, 0,      0,        1, 1, 2,      32'hA2,   3, 1);
    add("drain2",       0, 0,      0,        1, 1, 3,      32'hA3,   2, 1);
    add("drain3",       0, 0,      0,        1, 1, 32'h30, 32'hB0,   1, 1);
    add("drain_empty",  0, 0,      0,        1, 0, 0,      0,        0, 1);
    add("occ0",         1, 32'h40, 32'hC0,   1, 1, 32'h40, 32'hC0,   1, 1);
    add("occ1",         1, 32'h41, 32'hC1,   1, 1, 32'h41, 32'hC1,   1, 1);
    add("occ2",         1, 32'h42, 32'hC2,   1, 1, 32'h42, 32'hC2,   1, 1);
    add("occ_empty",    0, 0,      0,        1, 0, 0,      0,        0, 1);
    add("stall0",       1, 32'h50, 32'hD0,   0, 1, 32'h50, 32'hD0,   1, 1);
    add("stall1",       1, 32'h51, 32'hD1,   0, 1, 32'h50, 32'hD0,   2, 1);
    add("stall2",       1, 32'h52, 32'hD2,   0, 1, 32'h50, 32'hD0,   3, 1);
    add("stall3",       1, 32'h53, 32'hD3,   0, 1, 32'h50, 32'hD0,   4, 1);
    add("stall4",       1, 32'h54, 32'hD4,   0, 1, 32'h50, 32'hD0,   4, 1);
    add("pre_rst",      0, 0,      0,        1, 1, 32'h51, 32'hD1,   3, 1);

    #1 rst = 1'b1;
    #1;
    check_state("reset", 0, 0, 0, 0, 0);
    chk("reset.addr", bus_addr, 32'h0);
    chk("reset.data", bus_data, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].we, tv[i].a, tv[i].d, tv[i].rdy);
      step_check(tv[i].name, tv[i].v, tv[i].ea, tv[i].ed, tv[i].cnt, tv[i].ovf);
    end

    // Asynchronous reset in the middle of a cycle with three entries pending.
    drive(0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    check_state("rst_mid", 0, 0, 0, 0, 0);
    chk("rst_mid.addr", bus_addr, 32'h0);
    chk("rst_mid.data", bus_data, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst.valid", 32'(bus_valid), 32'h0);
    end

    // Repeated stores to the newest address, then a store while full.
    drive(1, 32'h60, 32'h1, 0);
    step_check("same0", 1, 32'h60, 32'h1, 1, 0);
    drive(1, 32'h60, 32'h2, 0);
`ifdef STORE_BUF_COALESCE_EN
    step_check("same1", 1, 32'h60, 32'h2, 1, 0);
    drive(1, 32'h61, 32'h3, 0); step_check("same_f1", 1, 32'h60, 32'h2, 2, 0);
    drive(1, 32'h62, 32'h4, 0); step_check("same_f2", 1, 32'h60, 32'h2, 3, 0);
    drive(1, 32'h63, 32'h5, 0); step_check("same_f3", 1, 32'h60, 32'h2, 4, 0);
    drive(1, 32'h63, 32'h9, 0); step_check("coal_full", 1, 32'h60, 32'h2, 4, 0);
`else
    step_check("same1", 1, 32'h60, 32'h1, 2, 0);
    drive(1, 32'h61, 32'h3, 0); step_check("same_f1", 1, 32'h60, 32'h1, 3, 0);
    drive(1, 32'h62, 32'h4, 0); step_check("same_f2", 1, 32'h60, 32'h1, 4, 0);
    drive(1, 32'h63, 32'h5, 0); step_check("same_f3", 1, 32'h60, 32'h1, 4, 1);
    drive(1, 32'h63, 32'h9, 0); step_check("coal_full", 1, 32'h60, 32'h1, 4, 1);
`endif
    drive(0, 0, 0, 1);
`ifdef STORE_BUF_COALESCE_EN
    step_check("tail_d1", 1, 32'h61, 32'h3, 3, 0);
    step_check("tail_d2", 1, 32'h62, 32'h4, 2, 0);
    step_check("tail_d3", 1, 32'h63, 32'h9, 1, 0);
`else
    step_check("tail_d1", 1, 32'h60, 32'h2, 3, 1);
    step_check("tail_d2", 1, 32'h61, 32'h3, 2, 1);
    step_check("tail_d3", 1, 32'h62, 32'h4, 1, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the core's data-memory port and the data-memory/peripheral bus. Captures every single-cycle store the core issues (`mem_we`, `mem_addr`, `mem_data`) into a small FIFO, then drains the FIFO one entry at a time to a slower valid/ready bus. The core never stalls: when the buffer is full, further stores are dropped and a sticky overflow flag is raised.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `ADDR_W`, default 32: store address width.
- `DATA_W`, default 32: store data width.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `mem_we`, in, 1: core store strobe; one store per cycle while high.
- `mem_addr`, in, ADDR_W: core store address.
- `mem_data`, in, DATA_W: core store data.
- `full`, out, 1: count == DEPTH.
- `empty`, out, 1: count == 0.
- `count`, out, $clog2(DEPTH)+1: number of valid entries.
- `overflow`, out, 1: sticky; a store was dropped.
- `bus_valid`, out, 1: head entry presented.
- `bus_addr`, out, ADDR_W: head address.
- `bus_data`, out, DATA_W: head data.
- `bus_ready`, in, 1: bus accepts the head this cycle.

## Operation
- Storage is a circular array with `wr_ptr`, `rd_ptr` (modulo DEPTH) and `count`.
- Definitions:
  - push = `mem_we` && (!full || pop).
  - pop = `bus_valid` && `bus_ready`.
- `bus_valid` = !empty. `bus_addr`/`bus_data` = entry[rd_ptr]. No combinational path from `mem_*` to `bus_*`.
- On pop: rd_ptr advances, count decrements.
- On push: entry[wr_ptr] ← {mem_addr, mem_data}, wr_ptr advances, count increments.
- Push and pop together: count unchanged. Both pointers advance. This is legal when full (the freed slot is reused) and when count == 1.
- Drop: `mem_we` && full && !pop. No state changes except `overflow` ← 1.
- `overflow` clears only on reset.
- Pointers wrap from DEPTH-1 to 0 with no gap.
- Ordering: entries drain strictly in push order. Addresses and data pass through unmodified.
- Bus rule: once `bus_valid` is high, head address and data stay stable until pop or reset.

## Timing
- Reset values (asynchronous):
  - count = 0, pointers = 0.
  - `empty` = 1, `full` = 0, `overflow` = 0, `bus_valid` = 0.
  - `bus_addr`/`bus_data` = 0: storage is cleared on reset.
- Latency: a store at edge N into an empty buffer gives `bus_valid` = 1 after edge N, and is visible in cycle N+1.
- Minimum occupancy: with `bus_ready` held high, each store occupies the buffer for exactly one cycle.
- Throughput: one push and one pop per cycle.
- `full`, `empty` and `count` are registered-state decodes that reflect the post-edge count.
- Reset mid-operation: all pending entries are discarded and `bus_valid` drops immediately. No partial bus transfer is defined.

## Configuration
- `STORE_BUF_COALESCE_EN`, when defined:
  - Condition: `mem_we` && count > 0 && `mem_addr` == address of the newest entry (wr_ptr-1) && !(count == 1 && pop).
  - Action: that entry's data is overwritten in place. count and wr_ptr are unchanged.
  - Coalescing takes priority over the full/drop rule, so such a store is never dropped and `overflow` is not set.
- When undefined: every accepted store creates a new entry and there is no address comparator.

## Structure
- Shared package `cpu_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults.
  - `sb_entry_t` = {addr, data}.
- Sub-module `sb_storage`: the DEPTH×entry register array with one write port, one asynchronous read port for the head, and one asynchronous read port for the newest entry (used by coalescing). Pointer, count and flag logic stay in `store_buffer`.

## Test plan
- Single store: `mem_we` for 1 cycle, addr 0x10, data 0xDEAD, `bus_ready` = 1. Next cycle `bus_valid` = 1, addr 0x10, data 0xDEAD. The following cycle `empty` = 1.
- Fill and drain: `bus_ready` = 0, push 4 stores (addr 0..3, data 0xA0..0xA3). Then `full` = 1 and count = 4. Raise `bus_ready`: entries drain in order 0xA0..0xA3 over 4 cycles, then `empty` = 1.
- Overflow: buffer full, `bus_ready` = 0, store addr 0x20. It is dropped, `overflow` = 1 and stays 1, and count stays 4. With `STORE_BUF_COALESCE_EN`, a store to addr 3 instead updates that entry's data and does not set `overflow`.
- Push with pop when full: full and `bus_ready` = 1, store 0xB0. The head pops, count stays 4, and 0xB0 drains last. Repeat past the pointer wrap with no loss.
- Stall stability: `bus_valid` = 1, `bus_ready` = 0 for 5 cycles while new stores arrive. `bus_addr`/`bus_data` stay constant throughout.
- Reset mid-drain: assert `rst` asynchronously with count = 3. Outputs go to reset values before the next edge, and no entry appears after `rst` deasserts.
